// File: rtl/gold_miner_pkg.sv
// gold_miner_pkg: definitions shared by the gold miner video blocks.
//   - stone RAM word field positions and the unpacked stone record
//   - stone type encodings and their pixel colours
//   - screen size used for clipping
//   - stone_drawer FSM state encoding and shadow entry layout
package gold_miner_pkg;

   localparam int unsigned STONE_X_MSB    = 31;
   localparam int unsigned STONE_X_LSB    = 23;
   localparam int unsigned STONE_Y_MSB    = 18;
   localparam int unsigned STONE_Y_LSB    = 11;
   localparam int unsigned STONE_TYPE_MSB = 3;
   localparam int unsigned STONE_TYPE_LSB = 2;
   localparam int unsigned STONE_VIS_BIT  = 1;
   localparam int unsigned STONE_MOV_BIT  = 0;

   localparam int unsigned SCREEN_W = 320;
   localparam int unsigned SCREEN_H = 240;

   typedef enum logic [1:0] {
      TYPE_STONE   = 2'b00,
      TYPE_GOLD    = 2'b01,
      TYPE_DIAMOND = 2'b10,
      TYPE_OTHER   = 2'b11
   } stone_type_e;

   localparam logic [2:0] COL_BLACK   = 3'b000;
   localparam logic [2:0] COL_STONE   = 3'b111;
   localparam logic [2:0] COL_GOLD    = 3'b110;
   localparam logic [2:0] COL_DIAMOND = 3'b011;
   localparam logic [2:0] COL_OTHER   = 3'b101;

   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
      logic [1:0] kind;
      logic       visible;
   } stone_t;

   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
      logic       visible;
   } shadow_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WAIT_FRAME,
      S_ADDR,
      S_RAM_WAIT,
      S_LATCH,
      S_ERASE,
      S_DRAW,
      S_NEXT,
      S_DONE
   } drawer_state_e;

   function automatic logic [2:0] type_colour(input logic [1:0] kind);
      case (stone_type_e'(kind))
         TYPE_STONE:   return COL_STONE;
         TYPE_GOLD:    return COL_GOLD;
         TYPE_DIAMOND: return COL_DIAMOND;
         default:      return COL_OTHER;
      endcase
   endfunction

   function automatic stone_t unpack_stone(input logic [31:0] w);
      stone_t s;
      s.x       = w[STONE_X_MSB:STONE_X_LSB];
      s.y       = w[STONE_Y_MSB:STONE_Y_LSB];
      s.kind    = w[STONE_TYPE_MSB:STONE_TYPE_LSB];
      s.visible = w[STONE_VIS_BIT];
      return s;
   endfunction

endpackage

// File: rtl/box_rasteriser.sv
// box_rasteriser: walks a 16x16 solid box one pixel per cycle, row-major.
//   start     in  : sample x/y/colour_in and emit pixel 0 on this edge
//   x, y      in  : top-left corner of the box
//   colour_in in  : fill colour
//   plot      out : registered write strobe, low for off-screen pixels
//   vga_x/y   out : registered pixel coordinate
//   colour    out : registered pixel colour
//   done      out : high in the cycle the last pixel is on the outputs
module box_rasteriser
   import gold_miner_pkg::*;
#(
   parameter logic [7:0] LAST_PIX = 8'hFF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [8:0] x,
   input  logic [7:0] y,
   input  logic [2:0] colour_in,
   output logic       plot,
   output logic [8:0] vga_x,
   output logic [7:0] vga_y,
   output logic [2:0] colour,
   output logic       done
);

   logic       active_q, active_d;
   logic [7:0] cnt_q, cnt_d;
   logic [8:0] base_x_q, base_x_d;
   logic [7:0] base_y_q, base_y_d;
   logic [2:0] base_col_q, base_col_d;
   logic       plot_q, plot_d;
   logic [8:0] vga_x_q, vga_x_d;
   logic [7:0] vga_y_q, vga_y_d;
   logic [2:0] colour_q, colour_d;
   logic       done_q, done_d;

   logic       emit;
   logic [7:0] pix;
   logic [8:0] bx;
   logic [7:0] by;
   logic [2:0] bc;
   logic [9:0] sum_x, sum_y;

   always_comb begin
      active_d   = active_q;
      cnt_d      = cnt_q;
      base_x_d   = base_x_q;
      base_y_d   = base_y_q;
      base_col_d = base_col_q;
      emit       = 1'b0;
      pix        = cnt_q;
      bx         = base_x_q;
      by         = base_y_q;
      bc         = base_col_q;
      // start bypasses the base registers so pixel 0 appears on the start edge
      if (start) begin
         emit       = 1'b1;
         pix        = '0;
         bx         = x;
         by         = y;
         bc         = colour_in;
         base_x_d   = x;
         base_y_d   = y;
         base_col_d = colour_in;
         cnt_d      = 8'd1;
         active_d   = 1'b1;
      end else if (active_q) begin
         emit  = 1'b1;
         cnt_d = cnt_q + 8'd1;
         if (cnt_q == LAST_PIX) begin
            active_d = 1'b0;
         end
      end
      // 10-bit sums so boxes near the right/bottom edge clip instead of wrapping
      sum_x    = {1'b0, bx} + {6'b0, pix[3:0]};
      sum_y    = {2'b0, by} + {6'b0, pix[7:4]};
      plot_d   = emit && (sum_x < 10'(SCREEN_W)) && (sum_y < 10'(SCREEN_H));
      vga_x_d  = emit ? sum_x[8:0] : '0;
      vga_y_d  = emit ? sum_y[7:0] : '0;
      colour_d = emit ? bc : '0;
      done_d   = emit && (pix == LAST_PIX);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         active_q   <= 1'b0;
         cnt_q      <= '0;
         base_x_q   <= '0;
         base_y_q   <= '0;
         base_col_q <= '0;
         plot_q     <= 1'b0;
         vga_x_q    <= '0;
         vga_y_q    <= '0;
         colour_q   <= '0;
         done_q     <= 1'b0;
      end else begin
         active_q   <= active_d;
         cnt_q      <= cnt_d;
         base_x_q   <= base_x_d;
         base_y_q   <= base_y_d;
         base_col_q <= base_col_d;
         plot_q     <= plot_d;
         vga_x_q    <= vga_x_d;
         vga_y_q    <= vga_y_d;
         colour_q   <= colour_d;
         done_q     <= done_d;
      end
   end

   assign plot   = plot_q;
   assign vga_x  = vga_x_q;
   assign vga_y  = vga_y_q;
   assign colour = colour_q;
   assign done   = done_q;

endmodule

// File: rtl/stone_drawer.sv
// stone_drawer: once per frame owns the stone RAM read port, walks slots
// 0..quantity-1 and draws each visible stone as a 16x16 box.
//   clock, reset     : system clock, synchronous active-high reset
//   enable           : allows new passes to start
//   quantity         : live slot count, sampled at pass start
//   read_data        : stone RAM word for draw_index (RAM_LATENCY cycles later)
//   draw_stone_flag  : high while this block owns the RAM read port
//   draw_index       : RAM read address
//   vga_x/vga_y/colour/plot : registered pixel-write interface
//   frame_done       : one-cycle pulse at the end of each pass
// Build option STONE_DRAWER_ERASE_EN: keeps a shadow of what was drawn per slot
// and blanks the old box when a stone moves or disappears.
module stone_drawer
   import gold_miner_pkg::*;
#(
   parameter int unsigned FRAME_CLOCK = 833_334,
   parameter int unsigned SPRITE_SIZE = 16,
   parameter int unsigned RAM_LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [3:0]  quantity,
   input  logic [31:0] read_data,
   output logic        draw_stone_flag,
   output logic [3:0]  draw_index,
   output logic [8:0]  vga_x,
   output logic [7:0]  vga_y,
   output logic [2:0]  colour,
   output logic        plot,
   output logic        frame_done
);

   localparam int unsigned   FW         = (FRAME_CLOCK > 1) ? $clog2(FRAME_CLOCK) : 1;
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CLOCK - 1);
   localparam logic [3:0]    WAIT_LAST  = 4'(RAM_LATENCY - 1);
   localparam logic [7:0]    LAST_PIX   = 8'(SPRITE_SIZE * SPRITE_SIZE - 1);

   drawer_state_e state_q, state_d;
   logic [FW-1:0] frame_cnt_q, frame_cnt_d;
   logic [3:0]    index_q, index_d;
   logic [3:0]    qty_q, qty_d;
   logic [3:0]    wait_q, wait_d;
   stone_t        stone_q, stone_d;
   stone_t        word;

   logic          rast_start;
   logic [8:0]    rast_x;
   logic [7:0]    rast_y;
   logic [2:0]    rast_col;
   logic          rast_done;

   logic          unused_word_bits;

   assign word             = unpack_stone(read_data);
   assign unused_word_bits = ^{read_data[22:19], read_data[10:4], read_data[STONE_MOV_BIT]};

`ifdef STONE_DRAWER_ERASE_EN
   shadow_t shadow_q [16];
   shadow_t shadow_d [16];
   shadow_t shadow_cur;
   logic    need_erase;

   assign shadow_cur = shadow_q[index_q];
   assign need_erase = shadow_cur.visible &&
                       (!word.visible || (shadow_cur.x != word.x) || (shadow_cur.y != word.y));

   always_comb begin
      shadow_d = shadow_q;
      if (state_q == S_NEXT) begin
         shadow_d[index_q] = '{x: stone_q.x, y: stone_q.y, visible: stone_q.visible};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < 16; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         shadow_q <= shadow_d;
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = '0;
      index_d     = index_q;
      qty_d       = qty_q;
      wait_d      = wait_q;
      stone_d     = stone_q;
      case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_WAIT_FRAME;
         end
         S_WAIT_FRAME: begin
            if (frame_cnt_q == FRAME_LAST) begin
               if (quantity == 4'd0) begin
                  state_d = S_DONE;
               end else begin
                  qty_d   = quantity;
                  index_d = '0;
                  state_d = S_ADDR;
               end
            end else begin
               frame_cnt_d = frame_cnt_q + 1'b1;
            end
         end
         S_ADDR: begin
            if (RAM_LATENCY <= 1) begin
               state_d = S_LATCH;
            end else begin
               wait_d  = 4'd1;
               state_d = S_RAM_WAIT;
            end
         end
         S_RAM_WAIT: begin
            if (wait_q >= WAIT_LAST) state_d = S_LATCH;
            else                     wait_d  = wait_q + 4'd1;
         end
         S_LATCH: begin
            stone_d = word;
`ifdef STONE_DRAWER_ERASE_EN
            if (need_erase)        state_d = S_ERASE;
            else if (word.visible) state_d = S_DRAW;
            else                   state_d = S_NEXT;
`else
            if (word.visible) state_d = S_DRAW;
            else              state_d = S_NEXT;
`endif
         end
`ifdef STONE_DRAWER_ERASE_EN
         S_ERASE: begin
            if (rast_done) state_d = stone_q.visible ? S_DRAW : S_NEXT;
         end
`endif
         S_DRAW: begin
            if (rast_done) state_d = S_NEXT;
         end
         S_NEXT: begin
            if (index_q == qty_q - 4'd1) begin
               state_d = S_DONE;
            end else begin
               index_d = index_q + 4'd1;
               state_d = S_ADDR;
            end
         end
         S_DONE: begin
            state_d = enable ? S_WAIT_FRAME : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The rasteriser is kicked on the edge that enters a box state, using the
   // next-state stone so the first pixel lines up with the first box cycle.
   always_comb begin
      rast_start = (state_d != state_q) && ((state_d == S_DRAW) || (state_d == S_ERASE));
      rast_x     = stone_d.x;
      rast_y     = stone_d.y;
      rast_col   = type_colour(stone_d.kind);
`ifdef STONE_DRAWER_ERASE_EN
      if (state_d == S_ERASE) begin
         rast_x   = shadow_cur.x;
         rast_y   = shadow_cur.y;
         rast_col = COL_BLACK;
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         frame_cnt_q <= '0;
         index_q     <= '0;
         qty_q       <= '0;
         wait_q      <= '0;
         stone_q     <= '0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         index_q     <= index_d;
         qty_q       <= qty_d;
         wait_q      <= wait_d;
         stone_q     <= stone_d;
      end
   end

   box_rasteriser #(
      .LAST_PIX (LAST_PIX)
   ) u_box (
      .clock     (clock),
      .reset     (reset),
      .start     (rast_start),
      .x         (rast_x),
      .y         (rast_y),
      .colour_in (rast_col),
      .plot      (plot),
      .vga_x     (vga_x),
      .vga_y     (vga_y),
      .colour    (colour),
      .done      (rast_done)
   );

   assign draw_stone_flag = (state_q == S_ADDR)  || (state_q == S_RAM_WAIT) ||
                            (state_q == S_LATCH) || (state_q == S_ERASE)    ||
                            (state_q == S_DRAW)  || (state_q == S_NEXT);
   assign frame_done      = (state_q == S_DONE);
   assign draw_index      = index_q;

endmodule

// File: doc/stone_drawer.md
# stone_drawer

Read-side client of the stone RAM: once per frame it takes the RAM read port by holding `draw_stone_flag`, walks every stone slot, and rasterises each visible stone as a 16x16 solid box into the VGA adapter's pixel-write interface. With the erase feature compiled in, it also clears each stone's previously drawn box when the stone moves or disappears. It sits beside the rope controller, which pauses its own RAM reads and writes while `draw_stone_flag` is high.

## Interface
- `FRAME_CLOCK`, 833_334: clock cycles between pass starts.
- `SPRITE_SIZE`, 16: box edge in pixels; fixed at 16, since the pixel counter splits as `cnt[7:4]`/`cnt[3:0]`.
- `RAM_LATENCY`, 2: cycles from `draw_index` valid to `read_data` valid.
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: allows new passes to start.
- `quantity` in 4: number of live slots; indices 0..quantity-1.
- `read_data` in 32: RAM word. [31:23] x, [18:11] y, [3:2] type, [1] visible, [0] moving.
- `draw_stone_flag` out 1: high while this block owns the RAM read port.
- `draw_index` out 4: RAM read address.
- `vga_x` out 9, `vga_y` out 8: pixel coordinate.
- `colour` out 3: pixel colour (RGB 1-bit each).
- `plot` out 1: pixel write strobe.
- `frame_done` out 1: one-cycle pulse at the end of each pass.

## Operation
- States: S_IDLE, S_WAIT_FRAME, S_ADDR, S_RAM_WAIT, S_LATCH, S_ERASE, S_DRAW, S_NEXT, S_DONE.
- S_IDLE: if `enable` is high, go to S_WAIT_FRAME.
- S_WAIT_FRAME: count from 0. At count FRAME_CLOCK-1:
  - if `quantity`=0, go to S_DONE;
  - otherwise set index 0, raise `draw_stone_flag`, go to S_ADDR.
- S_ADDR, then RAM_LATENCY-1 cycles of S_RAM_WAIT, then S_LATCH, which captures `read_data` into a stone register.
- S_ERASE (erase build only): if the shadow entry for this index is visible and its x/y differs from the new word, or the new word is invisible, plot 256 pixels at the shadow x/y in colour 3'b000.
- S_DRAW: if `visible` is set, plot 256 pixels.
  - Pixel counter `cnt` 8 bits; `vga_x = x + cnt[3:0]`, `vga_y = y + cnt[7:4]`.
  - `colour` by type: 00 stone 3'b111, 01 gold 3'b110, 10 diamond 3'b011, 11 3'b101.
  - Invisible words skip S_DRAW.
- Clipping: any pixel with `vga_x` ≥ 320 or `vga_y` ≥ 240 keeps its cycle but has `plot`=0. Sums are computed at 10 bits, so there is no wrap-around.
- S_NEXT:
  - Update the shadow entry with {x, y, visible}.
  - If index = `quantity`-1, go to S_DONE; otherwise increment the index and go to S_ADDR.
- S_DONE:
  - Drop `draw_stone_flag` and pulse `frame_done`.
  - Go to S_WAIT_FRAME if `enable` is high, otherwise S_IDLE.
- If `enable` falls mid-pass, the pass completes first.
- `quantity` is sampled once at pass start. A later change applies from the next pass.

## Timing
- On reset: all outputs 0, state S_IDLE, shadow cleared to invisible. Reset mid-pass drops `draw_stone_flag` at that edge.
- `draw_stone_flag` rises on entry to S_ADDR for index 0. It stays high continuously until the S_DONE edge, including during the RAM wait states.
- `draw_index` is stable from S_ADDR through S_LATCH.
- Pixel outputs are registered: `plot`, `vga_x`, `vga_y` and `colour` change together. The box covers one pixel per cycle, 256 consecutive cycles, in row-major order.
- Cycles per stone: 1 + RAM_LATENCY + (256 if erasing) + (256 if visible) + 1.
- Ticks are not queued. The frame counter runs only in S_WAIT_FRAME, so the period is FRAME_CLOCK plus the pass length.

## Configuration
- `STONE_DRAWER_ERASE_EN` defined: 16-entry shadow array of {x[8:0], y[7:0], visible} and the S_ERASE state are present.
- Not defined: no shadow array; S_LATCH goes straight to S_DRAW or S_NEXT. Clearing the screen is left to the background redraw.

## Structure
- Shared package `gold_miner_pkg`:
  - stone word field positions;
  - type encodings;
  - colour constants;
  - SCREEN_W=320, SCREEN_H=240.
- One sub-module, `box_rasteriser`:
  - inputs: start, x, y, colour;
  - outputs: the 256-cycle `plot`/`vga_x`/`vga_y`/`colour` sequence and a `done` pulse.
  - Reused by both S_ERASE and S_DRAW.

## Test plan
- FRAME_CLOCK=4, `quantity`=1, slot0 = x 100, y 50, type 01, visible → `draw_stone_flag` high; 256 plots covering (100..115, 50..65), `colour` 3'b110; `frame_done` pulses once; flag low afterwards.
- `quantity`=3, slot1 invisible → `draw_index` sequence 0,1,2; plots for slots 0 and 2 only (512 total); flag never drops mid-pass.
- Slot x 312, y 236 → exactly 8x4=32 cycles with `plot`=1; remaining 224 cycles have `plot`=0.
- `STONE_DRAWER_ERASE_EN`, slot moves from (100,50) to (104,50) between passes → second pass gives 256 black plots at (100,50), then 256 coloured plots at (104,50).
- `quantity`=0 → `frame_done` pulses every FRAME_CLOCK+1 cycles; `draw_stone_flag` and `plot` stay 0.
- Reset asserted at pixel 100 of a draw → next cycle: outputs 0, `draw_stone_flag` 0, S_IDLE; a fresh pass starts at pixel 0.
